// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one I-cache request at a time,
// buffers the returned word and hands {inst, pc} to decode, cancelling wrong-path fetches.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [63:0] if_to_id_bus,
  input  logic [33:0] bj_bus,
  output logic        inst_req_valid,
  input  logic        inst_req_ready,
  output logic [31:0] inst_addr,
  input  logic        inst_resp_valid,
  output logic        inst_resp_ready,
  input  logic [31:0] inst_rdata,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_cancel_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        drop_q, drop_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] cancel_cnt_q, cancel_cnt_d;
  logic        req_valid_q, resp_ready_q, hold_q;

  logic        redirect;
  logic [31:0] bj_pc;

  assign redirect = bj_bus[33] & bj_bus[32];
  assign bj_pc    = bj_bus[31:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_buf_d   = inst_buf_q;
    drop_d       = drop_q;
    fetch_cnt_d  = fetch_cnt_q;
    cancel_cnt_d = cancel_cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = bj_pc;
      end
      S_REQ: begin
        if (inst_req_ready) begin
          state_d = S_WAIT;
          // The old-PC request was accepted anyway; its response must be thrown away.
          if (redirect) begin
            drop_d = 1'b1;
            pc_d   = bj_pc;
          end
        end else if (redirect) begin
          pc_d = bj_pc;
        end
      end
      S_WAIT: begin
        if (inst_resp_valid) begin
          if (redirect || drop_q) begin
            cancel_cnt_d = cancel_cnt_q + 32'd1;
            drop_d       = 1'b0;
            state_d      = S_REQ;
            if (redirect) pc_d = bj_pc;
          end else begin
            inst_buf_d = inst_rdata;
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
          pc_d   = bj_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          cancel_cnt_d = cancel_cnt_q + 32'd1;
          pc_d         = bj_pc;
          state_d      = S_REQ;
        end else if (id_allowin) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          pc_d        = pc_q + 32'd4;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_buf_q   <= 32'h0;
      drop_q       <= 1'b0;
      fetch_cnt_q  <= 32'h0;
      cancel_cnt_q <= 32'h0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_buf_q   <= inst_buf_d;
      drop_q       <= drop_d;
      fetch_cnt_q  <= fetch_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
      req_valid_q  <= (state_d == S_REQ);
      resp_ready_q <= (state_d == S_WAIT);
      hold_q       <= (state_d == S_HOLD);
    end
  end

  // Valid is masked by a same-cycle redirect so decode never latches a wrong-path word.
  assign if_to_id_valid  = hold_q & ~redirect;
  assign if_to_id_bus    = hold_q ? {inst_buf_q, pc_q} : 64'h0;
  assign inst_req_valid  = req_valid_q;
  assign inst_addr       = pc_q;
  assign inst_resp_ready = resp_ready_q;
  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_cancel_cnt = cancel_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed cycle-by-cycle bench for if_fetch_stage: a vector table drives the
// memory/decode/redirect inputs and lists every expected output for that cycle.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic [33:0] bj_bus;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_addr;
  logic        inst_resp_valid;
  logic        inst_resp_ready;
  logic [31:0] inst_rdata;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_cancel_cnt;

  int checks;
  int failures;

  if_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_allowin      (id_allowin),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_bus    (if_to_id_bus),
    .bj_bus          (bj_bus),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .inst_addr       (inst_addr),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_ready (inst_resp_ready),
    .inst_rdata      (inst_rdata),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_cancel_cnt (perf_cancel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        allow;
    logic        bjv;
    logic        bjw;
    logic [31:0] bjpc;
    logic        rq_rdy;
    logic        rs_v;
    logic [31:0] rdata;
    logic        e_req_v;
    logic [31:0] e_addr;
    logic        e_rs_rdy;
    logic        e_id_v;
    logic [63:0] e_bus;
    logic [31:0] e_fetch;
    logic [31:0] e_cancel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic allow, input logic bjv, input logic bjw,
                              input logic [31:0] bjpc, input logic rq_rdy, input logic rs_v,
                              input logic [31:0] rdata, input logic e_req_v,
                              input logic [31:0] e_addr, input logic e_rs_rdy,
                              input logic e_id_v, input logic [63:0] e_bus,
                              input logic [31:0] e_fetch, input logic [31:0] e_cancel);
    vec_t v;
    v.allow = allow;     v.bjv = bjv;         v.bjw = bjw;       v.bjpc = bjpc;
    v.rq_rdy = rq_rdy;   v.rs_v = rs_v;       v.rdata = rdata;
    v.e_req_v = e_req_v; v.e_addr = e_addr;   v.e_rs_rdy = e_rs_rdy;
    v.e_id_v = e_id_v;   v.e_bus = e_bus;     v.e_fetch = e_fetch; v.e_cancel = e_cancel;
    return v;
  endfunction

  task automatic chk(input string tag, input string sig, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %h want %h", tag, sig, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk(tag, "inst_req_valid",  {63'h0, inst_req_valid},  {63'h0, v.e_req_v});
    chk(tag, "inst_addr",       {32'h0, inst_addr},       {32'h0, v.e_addr});
    chk(tag, "inst_resp_ready", {63'h0, inst_resp_ready}, {63'h0, v.e_rs_rdy});
    chk(tag, "if_to_id_valid",  {63'h0, if_to_id_valid},  {63'h0, v.e_id_v});
    chk(tag, "if_to_id_bus",    if_to_id_bus,             v.e_bus);
    chk(tag, "perf_fetch_cnt",  {32'h0, perf_fetch_cnt},  {32'h0, v.e_fetch});
    chk(tag, "perf_cancel_cnt", {32'h0, perf_cancel_cnt}, {32'h0, v.e_cancel});
  endtask

  // Inputs change at the falling edge; outputs are compared 2 time units later.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    id_allowin      = v.allow;
    bj_bus          = {v.bjv, v.bjw, v.bjpc};
    inst_req_ready  = v.rq_rdy;
    inst_resp_valid = v.rs_v;
    inst_rdata      = v.rdata;
    #2;
    check_outputs(tag, v);
    $display("%s: req_v=%b addr=%h resp_rdy=%b id_v=%b bus=%h fetch=%0d cancel=%0d",
             tag, inst_req_valid, inst_addr, inst_resp_ready, if_to_id_valid,
             if_to_id_bus, perf_fetch_cnt, perf_cancel_cnt);
  endtask

  vec_t rst_v;

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    id_allowin = 1'b0;
    bj_bus     = 34'h0;
    inst_req_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    inst_rdata      = 32'h0;

    rst_v = mk(0,0,0,0, 0,0,0, 0,32'h100,0,0,64'h0, 0,0);

    // Columns: allow bjv bjw bjpc | rq_rdy rs_v rdata | req_v addr rs_rdy id_v bus | fetch cancel
    vecs.push_back(mk(0,0,0,0,          0,0,0,            0,32'h100,0,0,64'h0, 0,0));
    vecs.push_back(mk(0,0,0,0,          1,0,0,            1,32'h100,0,0,64'h0, 0,0));
    vecs.push_back(mk(0,0,0,0,          0,1,32'h13,       0,32'h100,1,0,64'h0, 0,0));
    vecs.push_back(mk(1,0,0,0,          0,0,0,            0,32'h100,0,1,{32'h13,32'h100}, 0,0));
    vecs.push_back(mk(0,0,0,0,          1,0,0,            1,32'h104,0,0,64'h0, 1,0));
    vecs.push_back(mk(0,0,0,0,          0,1,32'h00500093, 0,32'h104,1,0,64'h0, 1,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,        1,0,0,            0,32'h104,0,1,{32'h00500093,32'h104}, 1,0));
    vecs.push_back(mk(1,0,0,0,          0,0,0,            0,32'h104,0,1,{32'h00500093,32'h104}, 1,0));
    vecs.push_back(mk(0,0,0,0,          1,0,0,            1,32'h108,0,0,64'h0, 2,0));
    vecs.push_back(mk(0,1,1,32'h200,    0,0,0,            0,32'h108,1,0,64'h0, 2,0));
    vecs.push_back(mk(0,1,0,32'h999,    0,0,0,            0,32'h200,1,0,64'h0, 2,0));
    vecs.push_back(mk(0,0,1,32'h888,    0,0,0,            0,32'h200,1,0,64'h0, 2,0));
    vecs.push_back(mk(0,0,0,0,          0,0,0,            0,32'h200,1,0,64'h0, 2,0));
    vecs.push_back(mk(1,0,0,0,          0,1,32'hDEADBEEF, 0,32'h200,1,0,64'h0, 2,0));
    vecs.push_back(mk(0,0,0,0,          0,0,0,            1,32'h200,0,0,64'h0, 2,1));
    vecs.push_back(mk(0,0,0,0,          1,0,0,            1,32'h200,0,0,64'h0, 2,1));
    vecs.push_back(mk(0,0,0,0,          0,1,32'h11111111, 0,32'h200,1,0,64'h0, 2,1));
    vecs.push_back(mk(1,1,1,32'h300,    0,0,0,            0,32'h200,0,0,{32'h11111111,32'h200}, 2,1));
    vecs.push_back(mk(0,1,1,32'h10C,    0,0,0,            1,32'h300,0,0,64'h0, 2,2));
    vecs.push_back(mk(0,1,1,32'h400,    1,0,0,            1,32'h10C,0,0,64'h0, 2,2));
    vecs.push_back(mk(0,0,0,0,          0,1,32'h22222222, 0,32'h400,1,0,64'h0, 2,2));
    vecs.push_back(mk(0,0,0,0,          1,0,0,            1,32'h400,0,0,64'h0, 2,3));
    vecs.push_back(mk(0,0,0,0,          0,1,32'h33333333, 0,32'h400,1,0,64'h0, 2,3));
    vecs.push_back(mk(1,0,0,0,          0,0,0,            0,32'h400,0,1,{32'h33333333,32'h400}, 2,3));
    vecs.push_back(mk(0,0,0,0,          0,0,0,            1,32'h404,0,0,64'h0, 3,3));

    repeat (3) @(posedge clk);
    #2;
    check_outputs("reset_hold", rst_v);
    $display("reset_hold: req_v=%b addr=%h bus=%h", inst_req_valid, inst_addr, if_to_id_bus);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back redirects while waiting: last target wins, one response dropped.
    apply("b2b_accept", mk(0,0,0,0,       1,0,0,            1,32'h404,0,0,64'h0, 3,3));
    apply("b2b_redir1", mk(0,1,1,32'h500, 0,0,0,            0,32'h404,1,0,64'h0, 3,3));
    apply("b2b_redir2", mk(0,1,1,32'h600, 0,0,0,            0,32'h500,1,0,64'h0, 3,3));
    apply("b2b_drop",   mk(0,0,0,0,       0,1,32'hBAD0BAD0, 0,32'h600,1,0,64'h0, 3,3));
    apply("b2b_req",    mk(0,0,0,0,       1,0,0,            1,32'h600,0,0,64'h0, 3,4));
    apply("b2b_resp",   mk(0,0,0,0,       0,1,32'h44444444, 0,32'h600,1,0,64'h0, 3,4));
    apply("b2b_hold",   mk(1,0,0,0,       0,0,0,            0,32'h600,0,1,{32'h44444444,32'h600}, 3,4));
    apply("ar_req",     mk(0,0,0,0,       1,0,0,            1,32'h604,0,0,64'h0, 4,4));
    apply("ar_wait",    mk(0,0,0,0,       0,0,0,            0,32'h604,1,0,64'h0, 4,4));

    // Asynchronous reset asserted mid-cycle while in S_WAIT.
    #1 rst = 1'b0;
    #1;
    check_outputs("async_rst", rst_v);
    $display("async_rst: req_v=%b addr=%h resp_rdy=%b fetch=%0d cancel=%0d",
             inst_req_valid, inst_addr, inst_resp_ready, perf_fetch_cnt, perf_cancel_cnt);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    apply("rel_idle",   mk(0,0,0,0,       1,0,0,            0,32'h100,0,0,64'h0, 0,0));
    apply("rel_req",    mk(0,0,0,0,       0,0,0,            1,32'h100,0,0,64'h0, 0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
